// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encodings, the reset-active level and the all-zero word.
package regfile_mp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam logic        RST_ACTIVE = 1'b0;
    localparam logic [63:0] ZERO_WORD  = 64'd0;

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Soft-clear sequencer: walks registers 1..NREG-1, one per cycle, and exposes
// its state, the current clear address and a one-cycle start strobe.
module regfile_mp_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output clr_state_e        state,
    output logic [ADDR_W-1:0] cnt,
    output logic              clr_start
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == LAST_ADDR) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_start = (state == ST_IDLE) && clr_req;
    end

    // Register 0 is hard-wired to zero, so the walk starts at 1 and holds at the last address.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt <= '0;
        end else if (clr_start) begin
            cnt <= ADDR_W'(1);
        end else if (state == ST_CLEAR && cnt != LAST_ADDR) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with priority writes, same-cycle read
// bypass, a per-register busy scoreboard and a sequential soft-clear engine.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  bset,
    input  logic [ADDR_W-1:0]     bset_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic [ADDR_W-1:0]     dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int                NREG = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;

    clr_state_e        clr_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_start;

    logic [ADDR_W-1:0] wa [NWR];
    logic [DATA_W-1:0] wd [NWR];
    logic [NWR-1:0]    wen;

    regfile_mp_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .state     (clr_state),
        .cnt       (clr_cnt),
        .clr_start (clr_start)
    );

    assign clr_busy = (clr_state == ST_CLEAR);

    // External writes are accepted only outside CLEAR and never to register 0.
    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa[k]  = waddr[k*ADDR_W +: ADDR_W];
        assign wd[k]  = wdata[k*DATA_W +: DATA_W];
        assign wen[k] = we[k] && (wa[k] != '0) && !clr_busy;
    end

    // Ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int r = 0; r < NREG; r++) mem[r] <= ZERO;
        end else begin
            if (clr_busy) mem[clr_cnt] <= ZERO;
            for (int k = 0; k < NWR; k++) begin
                if (wen[k]) mem[wa[k]] <= wd[k];
            end
        end
    end

    // Clears come before the set so an issue to the same register in the same cycle stays busy.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            busy <= '0;
        end else if (clr_start) begin
            busy <= '0;
        end else if (!clr_busy) begin
            for (int k = 0; k < NWR; k++) begin
                if (wen[k]) busy[wa[k]] <= 1'b0;
            end
            if (bset && bset_addr != '0) busy[bset_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        logic              hit;
        logic              valid;

        assign ra    = raddr[i*ADDR_W +: ADDR_W];
        assign valid = (rst != RST_ACTIVE) && (ra != '0) && re[i] && !clr_busy;

        always_comb begin
            val = mem[ra];
            hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && wa[k] == ra) begin
                    val = wd[k];
                    hit = 1'b1;
                end
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = valid ? val : ZERO;
        assign rbusy[i]                  = valid && busy[ra] && !hit;
    end

    assign dbg_data = (dbg_sel == '0) ? ZERO : mem[dbg_sel];

endmodule
